// File: rtl/shift_seq_ctrl_pkg.sv
// ============================================================================
// Module  : shift_seq_pkg
// Brief   : Shared types and constants for the shift-register sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TX_LOAD  = 3'd1,
    ST_TX_SHIFT = 3'd2,
    ST_RX_SHIFT = 3'd3,
    ST_RX_HOLD  = 3'd4
  } state_e;

  localparam logic [1:0] MODE_SISO_R = 2'b00;
  localparam logic [1:0] MODE_SISO_L = 2'b01;
  localparam logic [1:0] MODE_PISO   = 2'b10;
  localparam logic [1:0] MODE_PIPO   = 2'b11;

  typedef enum logic {
    GNT_TX = 1'b0,
    GNT_RX = 1'b1
  } grant_e;

endpackage

`default_nettype wire

// File: rtl/shift_seq_ctrl_if.sv
// ============================================================================
// Module  : shift_seq_ctrl_if
// Brief   : TX/RX handshake bundle between requesters and the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_seq_ctrl_if #(
  parameter int WIDTH = 4
) ();

  logic             tx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_ready;
  logic             tx_done;
  logic             ser_valid;
  logic             rx_start;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             rx_ready;

  modport master (
    output tx_valid, tx_data, rx_start, rx_ready,
    input  tx_ready, tx_done, ser_valid, rx_valid, rx_data
  );

  modport slave (
    input  tx_valid, tx_data, rx_start, rx_ready,
    output tx_ready, tx_done, ser_valid, rx_valid, rx_data
  );

endinterface

`default_nettype wire

// File: rtl/shift_seq_ctrl_err_monitor.sv
// ============================================================================
// Module  : seq_err_monitor
// Brief   : Saturating upset counter and sticky per-replica mismatch flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_err_monitor #(
  parameter int CNT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [2:0]       mismatch_i,
  input  wire logic             err_clr_i,
  output logic      [CNT_W-1:0] err_count_o,
  output logic      [2:0]       err_sticky_o
);

  logic [CNT_W-1:0] count_q;
  logic [2:0]       sticky_q;

  // Clear takes priority over any same-cycle increment or flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      sticky_q <= '0;
    end else if (err_clr_i) begin
      count_q  <= '0;
      sticky_q <= '0;
    end else begin
      if ((|mismatch_i) && (count_q != {CNT_W{1'b1}})) begin
        count_q <= count_q + 1'b1;
      end
      sticky_q <= sticky_q | mismatch_i;
    end
  end

  assign err_count_o  = count_q;
  assign err_sticky_o = sticky_q;

endmodule

`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
// ============================================================================
// Module  : shift_seq_ctrl
// Brief   : Sequences a TMR universal shift register for PISO TX and SISO RX
//           frames with round-robin arbitration. Upset monitor is built only
//           when SHIFT_SEQ_ERR_MON_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  shift_seq_ctrl_if.slave       bus,
  output logic      [1:0]       reg_mode,
  output logic                  reg_load,
  output logic                  reg_enable,
  output logic      [WIDTH-1:0] reg_parallel_in,
  input  wire logic [WIDTH-1:0] reg_parallel_out,
  input  wire logic [2:0]       mismatch,
  input  wire logic             err_clr,
  output logic      [CNT_W-1:0] err_count,
  output logic      [2:0]       err_sticky,
  output logic                  busy
);

  localparam int CB = $clog2(WIDTH);

  state_e           state_q, state_d;
  grant_e           last_q, last_d;
  logic [CB-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             w_take_tx;
  logic             w_last_bit;

  logic [1:0]       mode_q;
  logic             load_q, en_q, ser_valid_q, tx_done_q, rx_valid_q, busy_q;
  logic [WIDTH-1:0] pin_q;

  assign w_last_bit = (cnt_q == CB'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q + 1'b1;
    w_take_tx = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // On a tie, the requester that did not win last time is granted.
        w_take_tx = bus.tx_valid && (!bus.rx_start || (last_q == GNT_RX));
        if (w_take_tx) begin
          hold_d  = bus.tx_data;
          last_d  = GNT_TX;
          state_d = ST_TX_LOAD;
        end else if (bus.rx_start) begin
          last_d  = GNT_RX;
          state_d = ST_RX_SHIFT;
        end
      end
      ST_TX_LOAD:  state_d = ST_TX_SHIFT;
      ST_TX_SHIFT: if (w_last_bit) state_d = ST_IDLE;
      ST_RX_SHIFT: if (w_last_bit) state_d = ST_RX_HOLD;
      ST_RX_HOLD:  if (bus.rx_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      last_q      <= GNT_RX;
      cnt_q       <= '0;
      hold_q      <= '0;
      mode_q      <= MODE_PIPO;
      load_q      <= 1'b0;
      en_q        <= 1'b0;
      pin_q       <= '0;
      ser_valid_q <= 1'b0;
      tx_done_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      tx_done_q   <= (state_q == ST_TX_SHIFT) && (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      mode_q      <= MODE_PIPO;
      load_q      <= 1'b0;
      en_q        <= 1'b0;
      pin_q       <= '0;
      ser_valid_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      case (state_d)
        ST_TX_LOAD: begin
          mode_q <= MODE_PISO;
          load_q <= 1'b1;
          en_q   <= 1'b1;
          pin_q  <= hold_d;
        end
        ST_TX_SHIFT: begin
          mode_q      <= MODE_PISO;
          en_q        <= 1'b1;
          ser_valid_q <= 1'b1;
        end
        ST_RX_SHIFT: begin
          mode_q <= MODE_SISO_R;
          en_q   <= 1'b1;
        end
        ST_RX_HOLD: rx_valid_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign reg_mode        = mode_q;
  assign reg_load        = load_q;
  assign reg_enable      = en_q;
  assign reg_parallel_in = pin_q;
  assign busy            = busy_q;
  assign bus.tx_ready    = rst && (state_q == ST_IDLE);
  assign bus.tx_done     = tx_done_q;
  assign bus.ser_valid   = ser_valid_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_data     = rx_valid_q ? reg_parallel_out : '0;

`ifdef SHIFT_SEQ_ERR_MON_EN
  seq_err_monitor #(
    .CNT_W (CNT_W)
  ) u_err_mon (
    .clk          (clk),
    .rst          (rst),
    .mismatch_i   (mismatch),
    .err_clr_i    (err_clr),
    .err_count_o  (err_count),
    .err_sticky_o (err_sticky)
  );
`else
  logic w_unused_err;
  assign w_unused_err = ^{mismatch, err_clr};
  assign err_count    = '0;
  assign err_sticky   = '0;
`endif

endmodule

`default_nettype wire
